// File: rtl/cprv_wb_arbiter.sv
// Register-file write-port arbiter: fixed priority to the pipeline (P), starvation-forced grant to the long-latency unit (L).
// Optional same-cycle forwarding of the registered write is enabled by defining CPRV_WB_ARB_FWD_EN.
module cprv_wb_arbiter #(
    parameter  int DATA_WIDTH = 64,
    parameter  int STARVE_MAX = 4,
    localparam int CNT_WIDTH  = $clog2(STARVE_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p_valid_i,
    output logic                  p_ready_o,
    input  logic [4:0]            p_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] p_rd_data_i,
    input  logic                  l_valid_i,
    output logic                  l_ready_o,
    input  logic [4:0]            l_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] l_rd_data_i,
    output logic                  wr_en_o,
    output logic [4:0]            wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_src_o,
    output logic                  starve_o,
    input  logic [4:0]            rs1_addr_i,
    input  logic [4:0]            rs2_addr_i,
    output logic                  fwd1_hit_o,
    output logic                  fwd2_hit_o,
    output logic [DATA_WIDTH-1:0] fwd1_data_o,
    output logic [DATA_WIDTH-1:0] fwd2_data_o
);

    logic [CNT_WIDTH-1:0]  starve_cnt;
    logic                  force_l;
    logic                  grant_l;
    logic                  grant_p;

    logic                  wr_vld_p0;
    logic [4:0]            wr_addr_p0;
    logic [DATA_WIDTH-1:0] wr_data_p0;
    logic                  wr_src_p0;

    assign force_l   = (starve_cnt == CNT_WIDTH'(STARVE_MAX));
    assign grant_l   = l_valid_i & (~p_valid_i | force_l);
    assign grant_p   = p_valid_i & ~grant_l;
    assign p_ready_o = ~(l_valid_i & force_l);
    assign l_ready_o = ~p_valid_i | force_l;
    assign starve_o  = grant_l & p_valid_i & force_l;

    // Stage p0: registered write port; x0 targets complete the handshake but never assert the enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_vld_p0  <= 1'b0;
            wr_addr_p0 <= '0;
            wr_data_p0 <= '0;
            wr_src_p0  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (grant_l) begin
                wr_vld_p0  <= (l_rd_addr_i != 5'd0);
                wr_addr_p0 <= l_rd_addr_i;
                wr_data_p0 <= l_rd_data_i;
                wr_src_p0  <= 1'b1;
            end else if (grant_p) begin
                wr_vld_p0  <= (p_rd_addr_i != 5'd0);
                wr_addr_p0 <= p_rd_addr_i;
                wr_data_p0 <= p_rd_data_i;
                wr_src_p0  <= 1'b0;
            end else begin
                wr_vld_p0  <= 1'b0;
            end

            if (l_valid_i && !grant_l) begin
                if (!force_l)
                    starve_cnt <= starve_cnt + CNT_WIDTH'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    assign wr_en_o   = wr_vld_p0;
    assign wr_addr_o = wr_addr_p0;
    assign wr_data_o = wr_data_p0;
    assign wr_src_o  = wr_src_p0;

`ifdef CPRV_WB_ARB_FWD_EN
    assign fwd1_hit_o  = wr_vld_p0 & (wr_addr_p0 == rs1_addr_i) & (rs1_addr_i != 5'd0);
    assign fwd2_hit_o  = wr_vld_p0 & (wr_addr_p0 == rs2_addr_i) & (rs2_addr_i != 5'd0);
    assign fwd1_data_o = fwd1_hit_o ? wr_data_p0 : '0;
    assign fwd2_data_o = fwd2_hit_o ? wr_data_p0 : '0;
`else
    logic unused_rs;
    assign unused_rs   = ^{rs1_addr_i, rs2_addr_i};
    assign fwd1_hit_o  = 1'b0;
    assign fwd2_hit_o  = 1'b0;
    assign fwd1_data_o = '0;
    assign fwd2_data_o = '0;
`endif

endmodule

// File: doc/cprv_wb_arbiter.md
Name: cprv_wb_arbiter

Overview:
- Shares the single register-file write port between two producers:
  - the in-order pipeline writeback (P);
  - a long-latency unit such as mul/div or a late load (L).
- Fixed priority to P, with a starvation counter that forces a grant to L.
- Registered write-port outputs drive the regfile rd_addr/rd_en/rd_data inputs.
- Sits between the mem stage / long-latency unit and the writeback regfile.

Parameters:
- DATA_WIDTH, 64, width of write data.
- STARVE_MAX, 4, number of consecutive blocked L cycles before L is forced; legal range 1..255.
- CNT_WIDTH, $clog2(STARVE_MAX+1), starvation counter width (derived, do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_valid_i  in  1  pipeline write request.
- p_ready_o  out  1  pipeline request accepted this cycle when high with p_valid_i.
- p_rd_addr_i  in  5  pipeline destination register.
- p_rd_data_i  in  DATA_WIDTH  pipeline write data.
- l_valid_i  in  1  long-latency write request.
- l_ready_o  out  1  long-latency request accepted this cycle when high with l_valid_i.
- l_rd_addr_i  in  5  long-latency destination register.
- l_rd_data_i  in  DATA_WIDTH  long-latency write data.
- wr_en_o  out  1  regfile write enable (registered).
- wr_addr_o  out  5  regfile write address (registered).
- wr_data_o  out  DATA_WIDTH  regfile write data (registered).
- wr_src_o  out  1  source of the current write: 0 = P, 1 = L.
- starve_o  out  1  high in any cycle where L is granted by force.
- rs1_addr_i, rs2_addr_i  in  5 each  read addresses for forwarding.
- fwd1_hit_o, fwd2_hit_o  out  1 each  forward hit flags.
- fwd1_data_o, fwd2_data_o  out  DATA_WIDTH each  forwarded data.

Behaviour:
- Reset (asynchronous, rst_n low): wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_src_o=0, starve counter=0. All forwarding outputs read 0 while in reset.
- force_l is defined as starve_cnt == STARVE_MAX.
- Grant logic (combinational):
  - grant_l = l_valid_i & (~p_valid_i | force_l)
  - grant_p = p_valid_i & ~grant_l
- Ready outputs (combinational; neither depends on its own valid):
  - p_ready_o = ~(l_valid_i & force_l)
  - l_ready_o = ~p_valid_i | force_l
- starve_o = grant_l & p_valid_i & force_l.
- Requester rules: once valid is raised, the requester holds valid, addr and data stable until ready is sampled high. The arbiter does not check this; the bench asserts it.
- Latency: a request accepted at edge N appears on wr_en_o/wr_addr_o/wr_data_o/wr_src_o in cycle N+1, for exactly one cycle.
- With no grant: wr_en_o=0 next cycle; wr_addr_o, wr_data_o and wr_src_o hold their previous values.
- x0 writes: a request with rd_addr=0 still completes its handshake. wr_en_o stays 0 for it; addr, data and src update as normal.
- Starvation counter:
  - increments (saturating at STARVE_MAX) when l_valid_i & ~grant_l;
  - clears when grant_l is high or l_valid_i is low.
- Simultaneous requests: P wins unless force_l. When forced, L wins, P stalls one cycle, and the counter clears.
- At most one write per cycle; never two grants in one cycle.
- Reset mid-request: any write in flight is dropped, the counter clears, and the requesters must re-present after reset.

Optional Feature:
- Macro: CPRV_WB_ARB_FWD_EN.
- Defined:
  - fwdN_hit_o = wr_en_o & (wr_addr_o == rsN_addr_i) & (rsN_addr_i != 0)
  - fwdN_data_o = wr_data_o when hit, otherwise 0.
  - This forwards the registered write into decode in the same cycle it reaches the regfile.
- Undefined: the ports remain, fwd1_hit_o/fwd2_hit_o tie to 0, fwd1_data_o/fwd2_data_o tie to 0, and the rs address inputs are unused.

Test Plan:
- P only: p_valid=1, addr=5, data=0xDEAD on one cycle -> p_ready=1; next cycle wr_en=1, wr_addr=5, wr_data=0xDEAD, wr_src=0; wr_en=0 the following cycle.
- L only: l_valid=1, addr=7, data=0x1234 -> l_ready=1 same cycle; next cycle wr_en=1, addr=7, wr_src=1, starve_o=0.
- Contention with STARVE_MAX=4: P valid every cycle, L valid from cycle 0 ->
  - cycles 0-3: P granted, L blocked, counter 1..4;
  - cycle 4: starve_o=1, L granted, p_ready=0;
  - cycle 5: wr_src=1, counter back to 0.
- x0 suppression: p_valid=1, addr=0, data=0xFF -> p_ready=1; next cycle wr_en=0, wr_data=0xFF.
- Reset mid-operation: assert rst_n=0 while L is valid with counter=3 -> outputs zero immediately (asynchronous); after release, counter=0 and L needs 4 more blocked cycles before it is forced.
- Forwarding (macro defined): write addr=9, data=0xABC; in the output cycle rs1=9, rs2=0 -> fwd1_hit=1, fwd1_data=0xABC, fwd2_hit=0. Macro undefined -> both hits 0.
